// File: rtl/mem_ctrl_pkg.sv
// mem_ctrl_pkg: shared definitions for the RAM access controller.
//   state_t          - controller state encoding (IDLE, RD, WR, DONE)
//   DEF_ADDR_W       - default RAM word-address width (512 words)
//   DEF_DATA_W       - default data width
//   DEF_WAIT_CYCLES  - default extra strobe cycles beyond the first
//   RAM_DEPTH        - number of RAM words
//   wait_cnt_w()     - width of the wait counter for a given WAIT_CYCLES
package mem_ctrl_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RD   = 2'd1,
        WR   = 2'd2,
        DONE = 2'd3
    } state_t;

    localparam int DEF_ADDR_W      = 9;
    localparam int DEF_DATA_W      = 32;
    localparam int DEF_WAIT_CYCLES = 1;
    localparam int RAM_DEPTH       = 512;

    // max(1, clog2(wait_cycles+1)); a zero-width counter is not allowed.
    function automatic int wait_cnt_w(input int wait_cycles);
        return (wait_cycles < 1) ? 1 : $clog2(wait_cycles + 1);
    endfunction

endpackage

// File: rtl/mem_wait_timer.sv
// mem_wait_timer: loadable down-counter with a zero flag; times how long
// a RAM strobe is held.
//   clock      in  - rising-edge clock
//   clear      in  - synchronous active-high reset (count -> 0)
//   load       in  - load load_value (takes priority over dec)
//   load_value in  - value to load
//   dec        in  - decrement by one while count is non-zero
//   count      out - current count
//   zero       out - count == 0
module mem_wait_timer #(
    parameter int W = 1
) (
    input  logic         clock,
    input  logic         clear,
    input  logic         load,
    input  logic [W-1:0] load_value,
    input  logic         dec,
    output logic [W-1:0] count,
    output logic         zero
);

    always_ff @(posedge clock) begin
        if (clear) begin
            count <= '0;
        end else if (load) begin
            count <= load_value;
        end else if (dec && !zero) begin
            count <= count - W'(1);
        end
    end

    assign zero = (count == '0);

endmodule

// File: rtl/mem_access_ctrl.sv
// mem_access_ctrl: bus-side initiator for the 512-word datapath RAM.
// Turns one-cycle read/write requests (address from MAR, data from MDR)
// into RAM strobes held for WAIT_CYCLES+1 cycles, captures read data for
// MDR and pulses done (with err for an illegal read+write request).
//
// Request/completion handshake: req_read/req_write are sampled only in
// IDLE; a request is accepted on the edge where exactly one is high, and
// is finished by a one-cycle done pulse. busy is high from the accept edge
// until the edge after done. Requests seen outside IDLE are dropped; the
// control unit holds or re-issues them.
//
// Ports:
//   clock, clear            - clock, synchronous active-high reset
//   req_read, req_write     - access requests
//   mar_in, mdr_in          - address / write data, captured at accept
//   ram_rdata               - RAM read data (may be Z when not reading)
//   ram_read, ram_write     - RAM strobes (never both high)
//   ram_address, ram_wdata  - held address / write data
//   rd_data                 - last captured read word
//   busy, done, err         - status
//   rd_count, wr_count      - completed-access counters
//   dbg_state               - current FSM state, for observation
//
// Build option: MEM_ACCESS_COUNT_EN enables rd_count/wr_count; when
// undefined both counters are tied to zero.
module mem_access_ctrl
    import mem_ctrl_pkg::*;
#(
    parameter int ADDR_W      = DEF_ADDR_W,
    parameter int DATA_W      = DEF_DATA_W,
    parameter int WAIT_CYCLES = DEF_WAIT_CYCLES
) (
    input  logic              clock,
    input  logic              clear,
    input  logic              req_read,
    input  logic              req_write,
    input  logic [ADDR_W-1:0] mar_in,
    input  logic [DATA_W-1:0] mdr_in,
    input  logic [DATA_W-1:0] ram_rdata,
    output logic              ram_read,
    output logic              ram_write,
    output logic [ADDR_W-1:0] ram_address,
    output logic [DATA_W-1:0] ram_wdata,
    output logic [DATA_W-1:0] rd_data,
    output logic              busy,
    output logic              done,
    output logic              err,
    output logic [15:0]       rd_count,
    output logic [15:0]       wr_count,
    output state_t            dbg_state
);

    localparam int CNT_W = wait_cnt_w(WAIT_CYCLES);

    state_t           state;
    logic             accept;
    logic             tmr_dec;
    logic             tmr_zero;
    logic [CNT_W-1:0] tmr_count;

    // A legal accept reloads the timer on the same edge the FSM leaves IDLE.
    assign accept  = (state == IDLE) && (req_read ^ req_write);
    assign tmr_dec = (state == RD) || (state == WR);

    mem_wait_timer #(.W(CNT_W)) u_timer (
        .clock      (clock),
        .clear      (clear),
        .load       (accept),
        .load_value (CNT_W'(WAIT_CYCLES)),
        .dec        (tmr_dec),
        .count      (tmr_count),
        .zero       (tmr_zero)
    );

    always_ff @(posedge clock) begin
        if (clear) begin
            state       <= IDLE;
            ram_read    <= 1'b0;
            ram_write   <= 1'b0;
            ram_address <= '0;
            ram_wdata   <= '0;
            rd_data     <= '0;
            busy        <= 1'b0;
            done        <= 1'b0;
            err         <= 1'b0;
        end else begin
            done <= 1'b0;
            err  <= 1'b0;
            case (state)
                IDLE: begin
                    if (req_read && req_write) begin
                        // Illegal: no strobe, straight to completion with err.
                        state <= DONE;
                        busy  <= 1'b1;
                        done  <= 1'b1;
                        err   <= 1'b1;
                    end else if (req_read) begin
                        state       <= RD;
                        busy        <= 1'b1;
                        ram_read    <= 1'b1;
                        ram_address <= mar_in;
                    end else if (req_write) begin
                        state       <= WR;
                        busy        <= 1'b1;
                        ram_write   <= 1'b1;
                        ram_address <= mar_in;
                        ram_wdata   <= mdr_in;
                    end
                end
                RD: begin
                    if (tmr_zero) begin
                        state    <= DONE;
                        ram_read <= 1'b0;
                        rd_data  <= ram_rdata;
                        done     <= 1'b1;
                    end
                end
                WR: begin
                    if (tmr_zero) begin
                        state     <= DONE;
                        ram_write <= 1'b0;
                        done      <= 1'b1;
                    end
                end
                DONE: begin
                    state <= IDLE;
                    busy  <= 1'b0;
                end
                default: begin
                    state <= IDLE;
                    busy  <= 1'b0;
                end
            endcase
        end
    end

`ifdef MEM_ACCESS_COUNT_EN
    // Count only real completions (RD/WR -> DONE), never illegal requests.
    always_ff @(posedge clock) begin
        if (clear) begin
            rd_count <= '0;
            wr_count <= '0;
        end else if (tmr_zero) begin
            if (state == RD) begin
                rd_count <= rd_count + 16'd1;
            end
            if (state == WR) begin
                wr_count <= wr_count + 16'd1;
            end
        end
    end
`else
    assign rd_count = '0;
    assign wr_count = '0;
`endif

    assign dbg_state = state;

endmodule

// File: tb/tb_mem_access_ctrl.sv
// tb_mem_access_ctrl: self-checking bench for mem_access_ctrl.
// Instance u_dut uses WAIT_CYCLES=1 with a bench RAM (backdoor preload);
// instance u_dut0 uses WAIT_CYCLES=0 with a RAM whose word is a fixed
// function of the address, for back-to-back read cadence.
module tb_mem_access_ctrl;
    import mem_ctrl_pkg::*;

    localparam int WC = 1;

    logic clock = 1'b0;
    always #5 clock = ~clock;

    logic clear;

    // ---------------- instance A (WAIT_CYCLES = 1) ----------------
    logic        req_read, req_write;
    logic [8:0]  mar_in;
    logic [31:0] mdr_in;
    wire  [31:0] ram_rdata;
    logic        ram_read, ram_write;
    logic [8:0]  ram_address;
    logic [31:0] ram_wdata, rd_data;
    logic        busy, done, err;
    logic [15:0] rd_count, wr_count;
    state_t      dbg_state;

    mem_access_ctrl #(.ADDR_W(9), .DATA_W(32), .WAIT_CYCLES(WC)) u_dut (
        .clock(clock), .clear(clear),
        .req_read(req_read), .req_write(req_write),
        .mar_in(mar_in), .mdr_in(mdr_in), .ram_rdata(ram_rdata),
        .ram_read(ram_read), .ram_write(ram_write),
        .ram_address(ram_address), .ram_wdata(ram_wdata),
        .rd_data(rd_data), .busy(busy), .done(done), .err(err),
        .rd_count(rd_count), .wr_count(wr_count), .dbg_state(dbg_state)
    );

    // Bench RAM for A: one writer process, backdoor has priority.
    logic [31:0] ram [RAM_DEPTH];
    logic        bd_we;
    logic [8:0]  bd_addr;
    logic [31:0] bd_data;
    always @(posedge clock) begin
        if (bd_we) ram[bd_addr] <= bd_data;
        else if (ram_write) ram[ram_address] <= ram_wdata;
    end
    assign ram_rdata = ram_read ? ram[ram_address] : 32'hzzzz_zzzz;

    // ---------------- instance B (WAIT_CYCLES = 0) ----------------
    logic        req_read0, req_write0;
    logic [8:0]  mar_in0;
    logic [31:0] mdr_in0;
    wire  [31:0] ram_rdata0;
    logic        ram_read0, ram_write0;
    logic [8:0]  ram_address0;
    logic [31:0] ram_wdata0, rd_data0;
    logic        busy0, done0, err0;
    logic [15:0] rd_count0, wr_count0;
    state_t      dbg_state0;

    mem_access_ctrl #(.ADDR_W(9), .DATA_W(32), .WAIT_CYCLES(0)) u_dut0 (
        .clock(clock), .clear(clear),
        .req_read(req_read0), .req_write(req_write0),
        .mar_in(mar_in0), .mdr_in(mdr_in0), .ram_rdata(ram_rdata0),
        .ram_read(ram_read0), .ram_write(ram_write0),
        .ram_address(ram_address0), .ram_wdata(ram_wdata0),
        .rd_data(rd_data0), .busy(busy0), .done(done0), .err(err0),
        .rd_count(rd_count0), .wr_count(wr_count0), .dbg_state(dbg_state0)
    );

    function automatic logic [31:0] b_word(input logic [8:0] a);
        return {7'h2B, a, 7'h11, ~a};
    endfunction
    assign ram_rdata0 = ram_read0 ? b_word(ram_address0) : 32'hzzzz_zzzz;

    // ---------------- reference model state ----------------
    logic [31:0] ref_mem [RAM_DEPTH];
    logic [8:0]  written_q[$];
    logic [31:0] exp_rd_data;
    logic [15:0] exp_rd_cnt, exp_wr_cnt;
    logic [31:0] exp_rd_data0;
    logic [15:0] exp_rd_cnt0;

    int checks = 0;
    int errors = 0;

    task automatic tick();
        @(posedge clock);
        #1;
    endtask

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    // status order: {ram_read, ram_write, busy, done, err}
    task automatic check_status(input string tag, input logic [4:0] exp);
        check(tag, {27'b0, ram_read, ram_write, busy, done, err}, {27'b0, exp});
    endtask

    task automatic check_status0(input string tag, input logic [4:0] exp);
        check(tag, {27'b0, ram_read0, ram_write0, busy0, done0, err0}, {27'b0, exp});
    endtask

    task automatic check_counts(input string tag);
        check({tag, "_rdcnt"}, {16'b0, rd_count}, {16'b0, exp_rd_cnt});
        check({tag, "_wrcnt"}, {16'b0, wr_count}, {16'b0, exp_wr_cnt});
    endtask

    task automatic backdoor(input logic [8:0] a, input logic [31:0] d);
        bd_addr = a; bd_data = d; bd_we = 1'b1;
        tick();
        bd_we = 1'b0;
        ref_mem[a] = d;
        written_q.push_back(a);
    endtask

    // Read: strobe for WC+1 cycles after accept, then done with the word.
    task automatic do_read(input logic [8:0] addr);
        logic [31:0] exp_word;
        exp_word = ref_mem[addr];
        mar_in = addr; mdr_in = $urandom; req_read = 1'b1;
        tick();
        req_read = 1'b0; mar_in = 9'($urandom_range(0, 511)); mdr_in = $urandom;
        for (int c = 0; c <= WC; c++) begin
            check_status("rd_strobe", 5'b10100);
            check("rd_addr", {23'b0, ram_address}, {23'b0, addr});
            check("rd_early", rd_data, exp_rd_data);
            tick();
        end
        exp_rd_data = exp_word;
`ifdef MEM_ACCESS_COUNT_EN
        exp_rd_cnt = exp_rd_cnt + 16'd1;
`endif
        check_status("rd_done", 5'b00110);
        check("rd_data", rd_data, exp_rd_data);
        check_counts("rd");
        tick();
        check_status("rd_idle", 5'b00000);
        check("rd_hold", rd_data, exp_rd_data);
    endtask

    task automatic do_write(input logic [8:0] addr, input logic [31:0] data);
        mar_in = addr; mdr_in = data; req_write = 1'b1;
        tick();
        req_write = 1'b0; mar_in = 9'($urandom_range(0, 511)); mdr_in = $urandom;
        for (int c = 0; c <= WC; c++) begin
            check_status("wr_strobe", 5'b01100);
            check("wr_addr", {23'b0, ram_address}, {23'b0, addr});
            check("wr_wdata", ram_wdata, data);
            tick();
        end
        ref_mem[addr] = data;
        written_q.push_back(addr);
`ifdef MEM_ACCESS_COUNT_EN
        exp_wr_cnt = exp_wr_cnt + 16'd1;
`endif
        check_status("wr_done", 5'b00110);
        check("wr_rd_keep", rd_data, exp_rd_data);
        check_counts("wr");
        tick();
        check_status("wr_idle", 5'b00000);
    endtask

    task automatic do_illegal();
        mar_in = 9'($urandom_range(0, 511)); req_read = 1'b1; req_write = 1'b1;
        tick();
        req_read = 1'b0; req_write = 1'b0;
        check_status("ill_done", 5'b00111);
        check_counts("ill");
        check("ill_rd_keep", rd_data, exp_rd_data);
        tick();
        check_status("ill_idle", 5'b00000);
    endtask

    initial begin
        logic [8:0] a0;
        int         op;
        clear = 1'b1;
        req_read = 1'b0; req_write = 1'b0; mar_in = '0; mdr_in = '0;
        req_read0 = 1'b0; req_write0 = 1'b0; mar_in0 = '0; mdr_in0 = '0;
        bd_we = 1'b0; bd_addr = '0; bd_data = '0;
        exp_rd_data = '0; exp_rd_cnt = '0; exp_wr_cnt = '0;
        exp_rd_data0 = '0; exp_rd_cnt0 = '0;
        tick();
        tick();
        clear = 1'b0;

        // Reset state
        check_status("rst_status", 5'b00000);
        check("rst_addr", {23'b0, ram_address}, 32'h0);
        check("rst_wdata", ram_wdata, 32'h0);
        check("rst_rd_data", rd_data, 32'h0);
        check_counts("rst");
        check("rst_state", {30'b0, dbg_state}, {30'b0, IDLE});
        check_status0("rst_status0", 5'b00000);
        check("rst_rd_data0", rd_data0, 32'h0);

        // WAIT_CYCLES=0, read request held high: accept every 3 cycles.
        a0 = 9'($urandom_range(0, 511));
        mar_in0 = a0; req_read0 = 1'b1;
        for (int k = 0; k < 6; k++) begin
            tick();
            check_status0("b_strobe", 5'b10100);
            check("b_addr", {23'b0, ram_address0}, {23'b0, a0});
            tick();
            exp_rd_data0 = b_word(a0);
`ifdef MEM_ACCESS_COUNT_EN
            exp_rd_cnt0 = exp_rd_cnt0 + 16'd1;
`endif
            check_status0("b_done", 5'b00110);
            check("b_rd_data", rd_data0, exp_rd_data0);
            check("b_rdcnt", {16'b0, rd_count0}, {16'b0, exp_rd_cnt0});
            a0 = 9'($urandom_range(0, 511));
            mar_in0 = a0;
            if (k == 5) req_read0 = 1'b0;
            tick();
            check_status0("b_idle", 5'b00000);
            check("b_hold", rd_data0, exp_rd_data0);
        end
        tick();
        check_status0("b_stop", 5'b00000);

        // Directed: read preset word, write top address, read it back.
        backdoor(9'h055, 32'h0000_00AB);
        do_read(9'h055);
        do_write(9'h1FF, 32'hDEAD_BEEF);
        do_read(9'h1FF);
        do_illegal();

        // clear during the second write cycle, with a read request present.
        mar_in = 9'h0A3; mdr_in = 32'h1234_5678; req_write = 1'b1;
        tick();
        req_write = 1'b0;
        check_status("cw_first", 5'b01100);
        tick();
        check_status("cw_second", 5'b01100);
        clear = 1'b1; req_read = 1'b1;
        tick();
        clear = 1'b0; req_read = 1'b0;
        // RAM saw the strobe on at least one edge, so the word landed.
        ref_mem[9'h0A3] = 32'h1234_5678;
        written_q.push_back(9'h0A3);
        exp_rd_data = '0; exp_rd_cnt = '0; exp_wr_cnt = '0;
        check_status("cw_clear", 5'b00000);
        check("cw_addr", {23'b0, ram_address}, 32'h0);
        check("cw_wdata", ram_wdata, 32'h0);
        check("cw_rd_data", rd_data, 32'h0);
        check_counts("cw");
        check("cw_state", {30'b0, dbg_state}, {30'b0, IDLE});
        do_read(9'h0A3);

        // Randomized mix with idle gaps.
        repeat (30) begin
            repeat ($urandom_range(0, 2)) begin
                tick();
                check_status("gap_idle", 5'b00000);
            end
            op = $urandom_range(0, 3);
            if (op <= 1) begin
                do_read(written_q[$urandom_range(0, written_q.size() - 1)]);
            end else if (op == 2) begin
                do_write(9'($urandom_range(0, 511)), $urandom);
            end else begin
                do_illegal();
            end
        end

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
